four_bit_sequential_divider: RTL and testbench

FOUR_BIT_SEQUENTIAL_DIVIDER -- requirements
Module: four_bit_sequential_divider

---
 rtl/four_bit_sequential_divider_if.sv | 22 ++
 rtl/four_bit_sequential_divider.sv | 137 +++++++++++++
 tb/tb_four_bit_sequential_divider.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/four_bit_sequential_divider_if.sv
// Handshake and result bundle for the 4-bit sequential divider.
// master: start, Dividend, Divisor out; slave: Quotient, Remainder, busy, done, div_by_zero out.
interface four_bit_sequential_divider_if;
    logic       start;
    logic [3:0] Dividend;
    logic [3:0] Divisor;
    logic [3:0] Quotient;
    logic [3:0] Remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, Dividend, Divisor,
        input  Quotient, Remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, Dividend, Divisor,
        output Quotient, Remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/four_bit_sequential_divider.sv
// Unsigned 4-bit restoring divider, one quotient bit per clock, MSB first.
// Ports: clk, rst_n (async, active-low), bus (slave modport of the divider interface).
module four_bit_sequential_divider (
    input  logic clk,
    input  logic rst_n,
    four_bit_sequential_divider_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_dvd;
    logic [3:0] r_dvs;
    logic [3:0] r_rem;
    logic [3:0] r_q;
    logic [1:0] r_cnt;
    logic       r_dbz;
    logic [3:0] r_quotient;
    logic [3:0] r_remainder;

    logic       w_accept;
    logic       w_zero;
    logic       w_last;
    logic [4:0] w_p;
    logic [4:0] w_t;
    logic       w_qbit;
    logic [3:0] w_rem_nxt;

    logic       w_busy;
    logic       w_done;
    logic       w_dbz;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_zero   = (bus.Divisor == 4'd0);
    assign w_last   = (r_cnt == 2'd3);

    // Dividend register shifts left so its MSB is always the next bit.
    assign w_p       = {r_rem, r_dvd[3]};
    assign w_t       = w_p - {1'b0, r_dvs};
    assign w_qbit    = ~w_t[4];
    assign w_rem_nxt = w_t[4] ? w_p[3:0] : w_t[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_dbz  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_dbz  = r_dbz;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd       <= 4'd0;
            r_dvs       <= 4'd0;
            r_rem       <= 4'd0;
            r_q         <= 4'd0;
            r_cnt       <= 2'd0;
            r_dbz       <= 1'b0;
            r_quotient  <= 4'd0;
            r_remainder <= 4'd0;
        end else if (w_accept) begin
            r_dvd <= bus.Dividend;
            r_dvs <= bus.Divisor;
            r_rem <= 4'd0;
            r_q   <= 4'd0;
            r_cnt <= 2'd0;
            r_dbz <= w_zero;
            // Divide-by-zero skips RUN, so results load on this edge.
            if (w_zero) begin
                r_quotient  <= 4'hF;
                r_remainder <= bus.Dividend;
            end
        end else if (r_state == S_RUN) begin
            r_dvd <= {r_dvd[2:0], 1'b0};
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[2:0], w_qbit};
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
                r_quotient  <= {r_q[2:0], w_qbit};
                r_remainder <= w_rem_nxt;
            end
        end
    end

    assign bus.Quotient    = r_quotient;
    assign bus.Remainder   = r_remainder;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.div_by_zero = w_dbz;

endmodule

// File: tb/tb_four_bit_sequential_divider.sv
// Self-checking bench for four_bit_sequential_divider.
// Transaction-level model plus directed vectors and an exhaustive operand sweep.
module tb_four_bit_sequential_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    four_bit_sequential_divider_if bus();

    four_bit_sequential_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: edges left until results appear, plus pending arithmetic result.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic       m_dbz  = 1'b0;
    logic [3:0] m_q    = 4'd0;
    logic [3:0] m_r    = 4'd0;
    logic [3:0] m_pq   = 4'd0;
    logic [3:0] m_pr   = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_q    = 4'd0;
            m_r    = 4'd0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_q    = m_pq;
                m_r    = m_pr;
            end
        end else if (bus.start) begin
            if (bus.Divisor == 4'd0) begin
                m_done = 1'b1;
                m_dbz  = 1'b1;
                m_q    = 4'hF;
                m_r    = bus.Dividend;
            end else begin
                m_left = 4;
                m_pq   = bus.Dividend / bus.Divisor;
                m_pr   = bus.Dividend % bus.Divisor;
            end
        end
    end

    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] exp;
        act = {bus.busy, bus.done, bus.div_by_zero, bus.Quotient, bus.Remainder};
        exp = {(m_left > 0), m_done, m_dbz, m_q, m_r};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_model t=%0t got busy/done/dbz/q/r=%b expected %b",
                      $time, act, exp);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_op(input string name, input int a, input int b,
                         input int eq, input int er, input int edbz);
        int cyc;
        int nbusy;
        bit got;
        cyc = 0;
        nbusy = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.Dividend = 4'(a);
        bus.Divisor  = 4'(b);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.Dividend = 4'($urandom_range(15));
        bus.Divisor  = 4'($urandom_range(15));
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nbusy++;
            if (bus.done) got = 1'b1;
        end
        check({name, ".latency"}, got ? cyc : -1, edbz ? 1 : 5);
        check({name, ".busy_cycles"}, nbusy, edbz ? 0 : 4);
        check({name, ".quotient"}, int'(bus.Quotient), eq);
        check({name, ".remainder"}, int'(bus.Remainder), er);
        check({name, ".div_by_zero"}, int'(bus.div_by_zero), edbz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int qd;
        int rd;
        int t1;
        int t2;
        int cyc;

        bus.start    = 1'b0;
        bus.Dividend = 4'd0;
        bus.Divisor  = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        check("reset.outputs",
              int'({bus.busy, bus.done, bus.div_by_zero, bus.Quotient, bus.Remainder}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        do_op("13div3", 13, 3, 4, 1, 0);
        check("model.13div3.q", int'(m_q), 4);
        check("model.13div3.r", int'(m_r), 1);
        do_op("15div1", 15, 1, 15, 0, 0);
        do_op("2div9", 2, 9, 0, 2, 0);
        do_op("15div15", 15, 15, 1, 0, 0);
        do_op("7div0", 7, 0, 15, 7, 1);
        check("model.7div0.r", int'(m_r), 7);

        // Start during RUN must be ignored.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.Dividend = 4'd12;
        bus.Divisor  = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.Dividend = 4'd9;
        bus.Divisor  = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.Dividend = 4'd3;
        bus.Divisor  = 4'd7;
        ndone = 0;
        qd = -1;
        rd = -1;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                qd = int'(bus.Quotient);
                rd = int'(bus.Remainder);
            end
        end
        check("ignore_start.done_count", ndone, 1);
        check("ignore_start.quotient", qd, 2);
        check("ignore_start.remainder", rd, 2);

        // Asynchronous reset mid-RUN aborts the operation.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.Dividend = 4'd14;
        bus.Divisor  = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort.outputs_zero",
              int'({bus.busy, bus.done, bus.div_by_zero, bus.Quotient, bus.Remainder}), 0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort.no_done", ndone, 0);
        do_op("14div3", 14, 3, 4, 2, 0);

        // Held start: back-to-back operations one IDLE cycle apart.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.Dividend = 4'd6;
        bus.Divisor  = 4'd4;
        t1 = -1;
        t2 = -1;
        cyc = 0;
        while (t2 < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        bus.start = 1'b0;
        check("held_start.gap", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, 6);
        check("held_start.quotient", int'(bus.Quotient), 1);
        check("held_start.remainder", int'(bus.Remainder), 2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) do_op($sformatf("sweep_%0d_%0d", a, b), a, b, 15, a, 1);
                else do_op($sformatf("sweep_%0d_%0d", a, b), a, b, a / b, a % b, 0);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
